// File: rtl/latch_report_pkg.sv
// latch_report_pkg: shared FSM states, RX command codes and frame headers for latch_report_ctrl.
package latch_report_pkg;

    typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_DATA, WAIT_ACK, RELEASE} state_e;

    localparam logic [7:0] CMD_ACK1   = 8'h00;
    localparam logic [7:0] CMD_ACK2   = 8'h01;
    localparam logic [7:0] CMD_LATCH1 = 8'h02;
    localparam logic [7:0] CMD_LATCH2 = 8'h03;

    localparam logic [7:0] HDR_CH1 = 8'h00;
    localparam logic [7:0] HDR_CH2 = 8'h01;

    function automatic logic [7:0] hdr_of(input logic ch);
        return ch ? HDR_CH2 : HDR_CH1;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: retriggerable one-shot, output high for pPULSE cycles after the last start.
module pulse_stretch #(
    parameter int pPULSE = 4
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iStart,
    output logic oPulse
);

    localparam int CW = $clog2(pPULSE + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge iCLK) begin
        if (!iRSTn)
            cnt_q <= '0;
        else if (iStart)
            cnt_q <= CW'(pPULSE);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign oPulse = cnt_q != '0;

endmodule

// File: rtl/latch_report_ctrl.sv
// latch_report_ctrl: frames the two latched counter values onto the byte TX link,
// waits for the host ack and turns host commands into latch / reset-latch pulses.
module latch_report_ctrl
    import latch_report_pkg::*;
#(
    parameter int pWIDTH       = 64,
    parameter int pBYTES       = 5,
    parameter int pPULSE       = 4,
    parameter int pACK_TIMEOUT = 1000000
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iRdy1,
    input  logic              iRdy2,
    input  logic [pWIDTH-1:0] i1Value,
    input  logic [pWIDTH-1:0] i2Value,
    output logic              oResetLatch1,
    output logic              oResetLatch2,
    output logic              oLatch1,
    output logic              oLatch2,
    output logic [7:0]        oTxData,
    output logic              oTxValid,
    input  logic              iTxReady,
    input  logic [7:0]        iRxData,
    input  logic              iRxValid,
    output logic              oBusy,
    output logic              oBadCmd
);

    localparam int SW = 8 * pBYTES;
    localparam int IW = $clog2(pBYTES + 1);
    localparam int TW = pACK_TIMEOUT > 0 ? $clog2(pACK_TIMEOUT + 1) : 1;

    state_e         state_q;
    logic           ch_q;
    logic           ptr_q;
    logic [SW-1:0]  snap_q;
    logic [IW-1:0]  idx_q;
    logic [TW-1:0]  tmo_q;
    logic           tx_valid_q;
    logic [7:0]     tx_data_q;
    logic           bad_q;

    logic           xfer;
    logic           rx_ack;
    logic           rx_bad;
    logic           sel_d;
    logic           rdy_ch;
    logic           tmo_hit;
    logic [IW-1:0]  nxt_idx;
    logic [SW-1:0]  nxt_sh;
    logic           unused_hi;

    // Only the low pBYTES bytes of each value are ever reported.
    assign unused_hi = ^{i1Value[pWIDTH-1:SW], i2Value[pWIDTH-1:SW]};

    always_comb begin
        xfer    = tx_valid_q && iTxReady;
        rx_ack  = iRxValid && state_q == WAIT_ACK && iRxData == {7'b0, ch_q};
        rx_bad  = iRxValid && !rx_ack && (iRxData >= 8'h04 || iRxData <= CMD_ACK2);
        sel_d   = (iRdy1 && iRdy2) ? ptr_q : iRdy2;
        rdy_ch  = ch_q ? iRdy2 : iRdy1;
        tmo_hit = pACK_TIMEOUT != 0 && tmo_q == TW'(pACK_TIMEOUT);
        nxt_idx = state_q == SEND_HDR ? '0 : idx_q + 1'b1;
        nxt_sh  = snap_q << {nxt_idx, 3'b000};
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q    <= IDLE;
            ch_q       <= 1'b0;
            ptr_q      <= 1'b0;
            snap_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            bad_q      <= 1'b0;
        end else begin
            bad_q <= rx_bad;
            case (state_q)
                IDLE: if (iRdy1 || iRdy2) begin
                    ch_q       <= sel_d;
                    snap_q     <= sel_d ? i2Value[SW-1:0] : i1Value[SW-1:0];
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= hdr_of(sel_d);
                    state_q    <= SEND_HDR;
                end
                SEND_HDR, SEND_DATA: if (xfer) begin
                    if (state_q == SEND_DATA && idx_q == IW'(pBYTES - 1)) begin
                        tx_valid_q <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= WAIT_ACK;
                    end else begin
                        idx_q     <= nxt_idx;
                        tx_data_q <= nxt_sh[SW-1 -: 8];
                        state_q   <= SEND_DATA;
                    end
                end
                // An ack on the expiry edge takes priority over the resend.
                WAIT_ACK: if (rx_ack) begin
                    state_q <= RELEASE;
                end else if (tmo_hit) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= hdr_of(ch_q);
                    state_q    <= SEND_HDR;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                RELEASE: if (!rdy_ch) begin
                    ptr_q   <= ~ptr_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pulse_stretch #(.pPULSE(pPULSE)) u_rl1 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(rx_ack && !ch_q), .oPulse(oResetLatch1)
    );
    pulse_stretch #(.pPULSE(pPULSE)) u_rl2 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(rx_ack && ch_q), .oPulse(oResetLatch2)
    );
    pulse_stretch #(.pPULSE(pPULSE)) u_l1 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iRxValid && iRxData == CMD_LATCH1), .oPulse(oLatch1)
    );
    pulse_stretch #(.pPULSE(pPULSE)) u_l2 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iRxValid && iRxData == CMD_LATCH2), .oPulse(oLatch2)
    );

    assign oTxValid = tx_valid_q;
    assign oTxData  = tx_data_q;
    assign oBusy    = state_q != IDLE;
    assign oBadCmd  = bad_q;

endmodule
